mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Pipeline MEM stage of the MIPS pipelined processor: takes the EX/MEM pipeline register contents, performs data-memory loads and stores over a ready-handshake bus with byte, half and word sizing, and registers the MEM/WB fields consumed by the write-back stage. It stalls the pipeline while a memory access is outstanding. It aborts on misaligned addresses or bus timeout.

## Interface
- TIMEOUT_CYCLES, 64: REQ-state cycles without dmem_ready before abort (range 1–255).
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- EX_MEM_valid  in  1  slot holds a real instruction.
- EX_MEM_ALU  in  32  ALU result / effective address.
- EX_MEM_store_data  in  32  rt value for stores.
- EX_MEM_write_reg  in  5  destination register.
- EX_MEM_mem_read, EX_MEM_mem_write  in  1 each  load / store (never both).
- EX_MEM_size  in  2  00 byte, 01 half, 10 word (11 treated as word).
- EX_MEM_unsigned  in  1  zero-extend loads (lbu/lhu).
- EX_MEM_mem_to_reg, EX_MEM_reg_write  in  1 each  passed to WB.
- dmem_req  out  1  registered request.
- dmem_we  out  1  write strobe.
- dmem_addr  out  32  word address, bits[1:0]=0.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables; be[3]=bits[31:24].
- dmem_ready  in  1  access complete this cycle.
- dmem_rdata  in  32  read data, valid when dmem_ready.
- MEM_WB_valid, MEM_WB_ALU[32], MEM_WB_memory_data[32], MEM_WB_write_reg[5], MEM_WB_mem_to_reg, MEM_WB_reg_write  out  registered WB fields.
- mem_stall  out  1  combinational; hold EX_MEM and upstream.
- misaligned, bus_error  out  1 each  registered one-cycle pulses.

## Operation
- Access = EX_MEM_valid & (mem_read | mem_write). Non-access instruction: MEM_WB captures fields next edge, memory_data=0, no stall.
- Misaligned: half with addr[0]=1, word with addr[1:0]≠0. No bus activity. MEM_WB gets a bubble (valid=0, reg_write=0). misaligned pulses next cycle. No stall.
- FSM IDLE→REQ: in IDLE an aligned access asserts mem_stall. On that edge the block registers dmem_req=1, addr, we, be and wdata, and enters REQ.
- REQ: request held stable. dmem_ready=1 → mem_stall=0 that cycle. At the edge: MEM_WB captures the instruction, with memory_data = extended load (0 for stores). dmem_req drops and the FSM returns to IDLE.
- Timeout: counter clears on REQ entry and increments each REQ cycle without ready. At TIMEOUT_CYCLES: mem_stall=0, MEM_WB gets a bubble, bus_error pulses, return to IDLE. dmem_ready arriving after the abort is ignored.
- While mem_stall=1, MEM_WB is loaded with a bubble every edge.
- Byte lanes are big-endian: offset 0 maps to bits[31:24].
  - sb: wdata={4{b}}, be=1000>>off.
  - sh: wdata={2{h}}, be=1100 (off 0) or 0011 (off 2).
  - sw: be=1111.
  - Loads select the lane, then sign- or zero-extend to 32 bits.

## Timing
- Reset: FSM IDLE, counter 0; dmem_req, dmem_we, dmem_be, dmem_addr and dmem_wdata are 0. All MEM_WB outputs are 0; misaligned=0, bus_error=0.
- mem_stall is 0 during reset. Reset in REQ drops dmem_req after that edge, and the access is discarded.
- Non-access latency: 1 cycle, EX_MEM to MEM_WB.
- Memory latency: 1 IDLE cycle, then N REQ cycles until ready. Minimum 2 cycles total, stall = N cycles.
- dmem_ready while dmem_req=0 is ignored.
- Back-to-back accesses: the next access sees IDLE one cycle after completion, so dmem_req has ≥1 low cycle between accesses.

## Structure
- Package mips_mem_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state encoding (ST_IDLE/ST_REQ), byte-enable constants.
- Sub-module load_extend (combinational): rdata, addr[1:0], size, unsigned → 32-bit extended value.
- The FSM, timeout counter, store lane logic and MEM_WB register stay in mem_access_stage.

## Test plan
- ALU op: ALU=0x0000_1234, reg_write=1, write_reg=5 → next cycle MEM_WB_ALU=0x1234, write_reg=5, mem_stall=0, dmem_req never high.
- lb at addr 0x103, ready one REQ cycle later, rdata=0x1122_3380 → dmem_addr=0x100, MEM_WB_memory_data=0xFFFF_FF80. With unsigned=1 → 0x0000_0080. Stall is exactly 1 cycle.
- sh at addr 0x202, store_data=0x0000_BEEF, ready after 3 REQ cycles → dmem_we=1, be=0011, wdata=0xBEEF_BEEF, mem_stall high 3 cycles, MEM_WB_reg_write=0.
- lw at addr 0x301 → no dmem_req, misaligned pulse, MEM_WB_valid=0, no stall.
- TIMEOUT_CYCLES=4, lw with ready held low → stall 4 cycles, bus_error pulse, bubble in MEM_WB. A later ready pulse is ignored.
- Reset asserted in the second REQ cycle → dmem_req=0 and all outputs 0 after the edge. After reset, an lw with immediate ready completes normally.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared constants and types for the MEM stage.
// Size codes, FSM states, byte enables, MEM/WB bundle.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  localparam logic [3:0] BE_NONE  = 4'b0000;
  localparam logic [3:0] BE_BYTE0 = 4'b1000;
  localparam logic [3:0] BE_HALF0 = 4'b1100;
  localparam logic [3:0] BE_HALF1 = 4'b0011;
  localparam logic [3:0] BE_WORD  = 4'b1111;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] mem_data;
    logic [4:0]  write_reg;
    logic        mem_to_reg;
    logic        reg_write;
  } mem_wb_t;

  localparam mem_wb_t MEM_WB_BUBBLE = '0;

  // Size code 11 behaves as a word.
  function automatic logic is_misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic bad;
    bad = 1'b0;
    if (size == SZ_HALF)
      bad = off[0];
    else if (size != SZ_BYTE)
      bad = (off != 2'b00);
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between MEM stage and memory.
// master: req/we/addr/wdata/be out, ready/rdata in.
interface mem_access_stage_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    output dmem_be,
    input  dmem_ready,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_be,
    output dmem_ready,
    output dmem_rdata
  );

endinterface

// File: rtl/mem_access_stage_load_extend.sv
// Load lane select and sign/zero extension.
// Ports: rdata, off, size, zext in; data out.
module load_extend
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        zext,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        sign_b;
  logic        sign_h;

  // Big-endian: offset 0 is the top byte.
  always_comb begin
    lane_b = rdata[31:24];
    case (off)
      2'd0:    lane_b = rdata[31:24];
      2'd1:    lane_b = rdata[23:16];
      2'd2:    lane_b = rdata[15:8];
      default: lane_b = rdata[7:0];
    endcase
  end

  assign lane_h = off[1] ? rdata[15:0]
                         : rdata[31:16];

  assign sign_b = ~zext & lane_b[7];
  assign sign_h = ~zext & lane_h[15];

  always_comb begin
    data = rdata;
    unique case (1'b1)
      (size == SZ_BYTE):
        data = {{24{sign_b}}, lane_b};
      (size == SZ_HALF):
        data = {{16{sign_h}}, lane_h};
      default:
        data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: loads/stores over dmem bus,
// MEM/WB register, stall, misalign and timeout abort.
// Ports: clk, reset, EX_MEM_* in, dmem bus (master),
// MEM_WB_* out, mem_stall, misaligned, bus_error out.
module mem_access_stage
  import mips_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        EX_MEM_valid,
  input  logic [31:0] EX_MEM_ALU,
  input  logic [31:0] EX_MEM_store_data,
  input  logic [4:0]  EX_MEM_write_reg,
  input  logic        EX_MEM_mem_read,
  input  logic        EX_MEM_mem_write,
  input  logic [1:0]  EX_MEM_size,
  input  logic        EX_MEM_unsigned,
  input  logic        EX_MEM_mem_to_reg,
  input  logic        EX_MEM_reg_write,

  mem_access_stage_if.master dmem,

  output logic        MEM_WB_valid,
  output logic [31:0] MEM_WB_ALU,
  output logic [31:0] MEM_WB_memory_data,
  output logic [4:0]  MEM_WB_write_reg,
  output logic        MEM_WB_mem_to_reg,
  output logic        MEM_WB_reg_write,

  output logic        mem_stall,
  output logic        misaligned,
  output logic        bus_error
);

  localparam logic [7:0] TMO_LAST =
    8'(TIMEOUT_CYCLES - 1);

  logic [0:0]  state;
  logic [7:0]  tmo_cnt;

  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  mem_wb_t     wb_q;
  mem_wb_t     wb_nxt;

  logic [1:0]  off;
  logic        access;
  logic        bad;
  logic        in_idle;
  logic        in_req;
  logic        start;
  logic        done;
  logic        expire;

  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] ld_data;

  assign off     = EX_MEM_ALU[1:0];
  assign access  = EX_MEM_valid &
                   (EX_MEM_mem_read | EX_MEM_mem_write);
  assign bad     = access &
                   is_misaligned(EX_MEM_size, off);
  assign in_idle = (state == ST_IDLE);
  assign in_req  = (state == ST_REQ);

  assign start  = in_idle & access & ~bad;
  assign done   = in_req & dmem.dmem_ready;
  // Last allowed REQ cycle passes without ready.
  assign expire = in_req & ~dmem.dmem_ready &
                  (tmo_cnt == TMO_LAST);

  assign mem_stall = ~reset &
                     (start | (in_req & ~done & ~expire));

  // Store lanes, replicated so any enabled lane is right.
  always_comb begin
    be_nxt    = BE_WORD;
    wdata_nxt = EX_MEM_store_data;
    unique case (1'b1)
      (EX_MEM_size == SZ_BYTE): begin
        be_nxt    = BE_BYTE0 >> off;
        wdata_nxt = {4{EX_MEM_store_data[7:0]}};
      end
      (EX_MEM_size == SZ_HALF): begin
        be_nxt    = off[1] ? BE_HALF1 : BE_HALF0;
        wdata_nxt = {2{EX_MEM_store_data[15:0]}};
      end
      default: begin
        be_nxt    = BE_WORD;
        wdata_nxt = EX_MEM_store_data;
      end
    endcase
  end

  load_extend u_load_extend (
    .rdata (dmem.dmem_rdata),
    .off   (off),
    .size  (EX_MEM_size),
    .zext  (EX_MEM_unsigned),
    .data  (ld_data)
  );

  // Anything other than a clean pass or completion
  // becomes a bubble.
  always_comb begin
    wb_nxt = MEM_WB_BUBBLE;
    if (in_idle && EX_MEM_valid && !access) begin
      wb_nxt.valid      = 1'b1;
      wb_nxt.alu        = EX_MEM_ALU;
      wb_nxt.mem_data   = '0;
      wb_nxt.write_reg  = EX_MEM_write_reg;
      wb_nxt.mem_to_reg = EX_MEM_mem_to_reg;
      wb_nxt.reg_write  = EX_MEM_reg_write;
    end else if (done) begin
      wb_nxt.valid      = 1'b1;
      wb_nxt.alu        = EX_MEM_ALU;
      wb_nxt.mem_data   = EX_MEM_mem_read ? ld_data
                                          : '0;
      wb_nxt.write_reg  = EX_MEM_write_reg;
      wb_nxt.mem_to_reg = EX_MEM_mem_to_reg;
      wb_nxt.reg_write  = EX_MEM_reg_write;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      tmo_cnt    <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= BE_NONE;
      wb_q       <= MEM_WB_BUBBLE;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      wb_q       <= wb_nxt;
      misaligned <= in_idle & bad;
      bus_error  <= expire;
      if (start) begin
        state   <= ST_REQ;
        tmo_cnt <= '0;
        req_q   <= 1'b1;
        we_q    <= EX_MEM_mem_write;
        addr_q  <= {EX_MEM_ALU[31:2], 2'b00};
        wdata_q <= wdata_nxt;
        be_q    <= be_nxt;
      end else if (done || expire) begin
        state   <= ST_IDLE;
        req_q   <= 1'b0;
        we_q    <= 1'b0;
      end else if (in_req) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_be    = be_q;

  assign MEM_WB_valid       = wb_q.valid;
  assign MEM_WB_ALU         = wb_q.alu;
  assign MEM_WB_memory_data = wb_q.mem_data;
  assign MEM_WB_write_reg   = wb_q.write_reg;
  assign MEM_WB_mem_to_reg  = wb_q.mem_to_reg;
  assign MEM_WB_reg_write   = wb_q.reg_write;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed steps then
// random ops checked against a behavioural model.
module tb_mem_access_stage;
  import mips_mem_pkg::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ex_alu;
  logic [31:0] ex_sd;
  logic [4:0]  ex_wr;
  logic        ex_rd;
  logic        ex_wt;
  logic [1:0]  ex_size;
  logic        ex_uns;
  logic        ex_m2r;
  logic        ex_rw;

  logic        wb_valid;
  logic [31:0] wb_alu;
  logic [31:0] wb_mem;
  logic [4:0]  wb_wr;
  logic        wb_m2r;
  logic        wb_rw;
  logic        mem_stall;
  logic        misaligned;
  logic        bus_error;

  int errors = 0;
  int checks = 0;

  mem_access_stage_if bus ();

  mem_access_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk                (clk),
    .reset              (reset),
    .EX_MEM_valid       (ex_valid),
    .EX_MEM_ALU         (ex_alu),
    .EX_MEM_store_data  (ex_sd),
    .EX_MEM_write_reg   (ex_wr),
    .EX_MEM_mem_read    (ex_rd),
    .EX_MEM_mem_write   (ex_wt),
    .EX_MEM_size        (ex_size),
    .EX_MEM_unsigned    (ex_uns),
    .EX_MEM_mem_to_reg  (ex_m2r),
    .EX_MEM_reg_write   (ex_rw),
    .dmem               (bus),
    .MEM_WB_valid       (wb_valid),
    .MEM_WB_ALU         (wb_alu),
    .MEM_WB_memory_data (wb_mem),
    .MEM_WB_write_reg   (wb_wr),
    .MEM_WB_mem_to_reg  (wb_m2r),
    .MEM_WB_reg_write   (wb_rw),
    .mem_stall          (mem_stall),
    .misaligned         (misaligned),
    .bus_error          (bus_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(
    input logic [31:0] d, input int o,
    input logic [1:0] sz, input logic u);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = (d >> (8 * (3 - o))) & 32'hFF;
      if (!u && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = (d >> (8 * (2 - o))) & 32'hFFFF;
      if (!u && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "/wb_valid"}, 32'(wb_valid), 0);
    chk({tag, "/wb_alu"}, wb_alu, 0);
    chk({tag, "/wb_mem"}, wb_mem, 0);
    chk({tag, "/wb_wr"}, 32'(wb_wr), 0);
    chk({tag, "/wb_m2r"}, 32'(wb_m2r), 0);
    chk({tag, "/wb_rw"}, 32'(wb_rw), 0);
    chk({tag, "/misaligned"}, 32'(misaligned), 0);
    chk({tag, "/bus_error"}, 32'(bus_error), 0);
    chk({tag, "/req"}, 32'(bus.dmem_req), 0);
    chk({tag, "/we"}, 32'(bus.dmem_we), 0);
    chk({tag, "/be"}, 32'(bus.dmem_be), 0);
    chk({tag, "/addr"}, bus.dmem_addr, 0);
    chk({tag, "/wdata"}, bus.dmem_wdata, 0);
  endtask

  // Entered and left at posedge+1. lat = REQ cycle in
  // which ready arrives; 0 means never (timeout).
  task automatic run_op(
    input string tag,
    input logic rd, input logic wt,
    input logic [1:0] sz, input logic uns,
    input logic [31:0] alu, input logic [31:0] sd,
    input logic [31:0] rdat, input logic [4:0] wr,
    input logic rw, input logic m2r, input int lat);
    int o, k, stalls, exp_stall;
    logic acc, bad, st, fin, tmo;
    logic [3:0] exp_be;
    logic [31:0] exp_wd, exp_mem;
    ex_valid = 1'b1;
    ex_alu = alu; ex_sd = sd; ex_wr = wr;
    ex_rd = rd; ex_wt = wt; ex_size = sz;
    ex_uns = uns; ex_m2r = m2r; ex_rw = rw;
    o = int'(alu[1:0]);
    acc = rd | wt;
    bad = acc && ((sz == 2'b01 && alu[0]) ||
                  (sz[1] && alu[1:0] != 2'b00));
    tmo = acc && !bad && lat == 0;
    exp_stall = (!acc || bad) ? 0 : (tmo ? TMO : lat);
    if (sz == 2'b00) begin
      exp_be = 4'(1 << (3 - o));
      exp_wd = 32'(sd[7:0]) * 32'h0101_0101;
    end else if (sz == 2'b01) begin
      exp_be = 4'(3 << (2 - o));
      exp_wd = 32'(sd[15:0]) * 32'h0001_0001;
    end else begin
      exp_be = 4'hF;
      exp_wd = sd;
    end
    exp_mem = rd ? ref_load(rdat, o, sz, uns) : 0;
    k = 0; stalls = 0; fin = 1'b0;
    for (int c = 0; c < 16 && !fin; c++) begin
      if (bus.dmem_req) begin
        k++;
        bus.dmem_ready = (k == lat);
        bus.dmem_rdata = (k == lat) ? rdat : $urandom;
        if (k == 1) begin
          chk({tag, "/addr"}, bus.dmem_addr,
              {alu[31:2], 2'b00});
          chk({tag, "/we"}, 32'(bus.dmem_we), 32'(wt));
          if (wt) begin
            chk({tag, "/be"}, 32'(bus.dmem_be),
                32'(exp_be));
            chk({tag, "/wdata"}, bus.dmem_wdata, exp_wd);
          end
        end
      end else begin
        bus.dmem_ready = 1'($urandom_range(0, 1));
        bus.dmem_rdata = $urandom;
      end
      @(negedge clk);
      st = mem_stall;
      if (st) stalls++;
      @(posedge clk); #1;
      if (!st) fin = 1'b1;
    end
    bus.dmem_ready = 1'b0;
    chk({tag, "/finished"}, 32'(fin), 1);
    chk({tag, "/stall_cycles"}, stalls, exp_stall);
    chk({tag, "/req_cycles"}, k, exp_stall);
    chk({tag, "/req_after"}, 32'(bus.dmem_req), 0);
    chk({tag, "/misaligned"}, 32'(misaligned),
        32'(bad));
    chk({tag, "/bus_error"}, 32'(bus_error), 32'(tmo));
    if (bad || tmo) begin
      chk({tag, "/wb_valid"}, 32'(wb_valid), 0);
      chk({tag, "/wb_rw"}, 32'(wb_rw), 0);
    end else begin
      chk({tag, "/wb_valid"}, 32'(wb_valid), 1);
      chk({tag, "/wb_alu"}, wb_alu, alu);
      chk({tag, "/wb_wr"}, 32'(wb_wr), 32'(wr));
      chk({tag, "/wb_rw"}, 32'(wb_rw), 32'(rw));
      chk({tag, "/wb_m2r"}, 32'(wb_m2r), 32'(m2r));
      chk({tag, "/wb_mem"}, wb_mem, exp_mem);
    end
  endtask

  initial begin
    int kind;
    logic [1:0] rsz;
    reset = 1'b1;
    ex_valid = 0; ex_alu = 0; ex_sd = 0; ex_wr = 0;
    ex_rd = 0; ex_wt = 0; ex_size = 0; ex_uns = 0;
    ex_m2r = 0; ex_rw = 0;
    bus.dmem_ready = 1'b0;
    bus.dmem_rdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    chk("reset/stall", 32'(mem_stall), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_op("alu", 0, 0, SZ_WORD, 0, 32'h0000_1234, 0,
           0, 5'd5, 1, 0, 1);
    run_op("lb", 1, 0, SZ_BYTE, 0, 32'h0000_0103, 0,
           32'h1122_3380, 5'd7, 1, 1, 1);
    chk("lb/value", wb_mem, 32'hFFFF_FF80);
    run_op("lbu", 1, 0, SZ_BYTE, 1, 32'h0000_0103, 0,
           32'h1122_3380, 5'd7, 1, 1, 1);
    chk("lbu/value", wb_mem, 32'h0000_0080);
    run_op("sh", 0, 1, SZ_HALF, 0, 32'h0000_0202,
           32'h0000_BEEF, 0, 5'd0, 0, 0, 3);
    run_op("lw_mis", 1, 0, SZ_WORD, 0, 32'h0000_0301, 0,
           0, 5'd9, 1, 1, 1);
    run_op("lw_tmo", 1, 0, SZ_WORD, 0, 32'h0000_0500, 0,
           0, 5'd3, 1, 1, 0);

    // Late ready after the abort must be ignored.
    ex_valid = 1'b0; ex_rd = 0; ex_wt = 0;
    bus.dmem_ready = 1'b1;
    bus.dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("late/stall", 32'(mem_stall), 0);
    @(posedge clk); #1;
    bus.dmem_ready = 1'b0;
    chk("late/wb_valid", 32'(wb_valid), 0);
    chk("late/bus_error", 32'(bus_error), 0);
    chk("late/req", 32'(bus.dmem_req), 0);

    // Reset in the second REQ cycle.
    ex_valid = 1'b1; ex_alu = 32'h0000_0400;
    ex_rd = 1; ex_wt = 0; ex_size = SZ_WORD;
    ex_rw = 1; ex_m2r = 1; ex_wr = 5'd4;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_req/req", 32'(bus.dmem_req), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_req/stall", 32'(mem_stall), 0);
    @(posedge clk); #1;
    check_all_zero("rst_req");
    reset = 1'b0;
    ex_valid = 1'b0;
    @(posedge clk); #1;
    run_op("lw_after_rst", 1, 0, SZ_WORD, 0,
           32'h0000_0400, 0, 32'hCAFE_F00D, 5'd4,
           1, 1, 1);

    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 2));
      rsz = 2'($urandom_range(0, 3));
      run_op("rand", kind == 1, kind == 2, rsz,
             1'($urandom_range(0, 1)), $urandom,
             $urandom, $urandom,
             5'($urandom_range(0, 31)),
             kind == 2 ? 1'b0
                       : (kind == 1 ? 1'b1
                          : 1'($urandom_range(0, 1))),
             kind == 1,
             int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
